// File: rtl/uart_alu_bridge.sv
// uart_alu_bridge: frames UART RX bytes into ALU operand A/B/opcode, queues each ALU result
// in a small TX FIFO and drains it to the UART TX. Optional inter-byte timeout: UART_AUX_TIMEOUT_EN.

module uart_alu_bridge #(
  parameter int N_BITS_DATA    = 8,
  parameter int N_BITS_OP      = 6,
  parameter int FIFO_ADDR_BITS = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_BITS_DATA-1:0] rx_data_i,
  input  logic                   rx_done_i,
  output logic [N_BITS_DATA-1:0] alu_a_o,
  output logic [N_BITS_DATA-1:0] alu_b_o,
  output logic [N_BITS_OP-1:0]   alu_op_o,
  input  logic [N_BITS_DATA-1:0] alu_result_i,
  output logic                   tx_start_o,
  output logic [N_BITS_DATA-1:0] tx_data_o,
  input  logic                   tx_done_i,
  output logic                   fifo_full_o,
  output logic                   overrun_o,
  output logic                   timeout_o
);

  localparam int DEPTH = 1 << FIFO_ADDR_BITS;
  localparam logic [FIFO_ADDR_BITS:0] CNT_FULL = (FIFO_ADDR_BITS+1)'(DEPTH);

  typedef enum logic [1:0] {GET_A, GET_B, GET_OP, EXEC} rxState_t;
  typedef enum logic {TX_IDLE, TX_WAIT} txState_t;

  rxState_t rxState_q, rxState_d;
  txState_t txState_q, txState_d;
  logic [N_BITS_DATA-1:0] aluA_q, aluA_d;
  logic [N_BITS_DATA-1:0] aluB_q, aluB_d;
  logic [N_BITS_OP-1:0]   aluOp_q, aluOp_d;
  logic [N_BITS_DATA-1:0] txData_q, txData_d;
  logic txStart_q, txStart_d;
  logic fifoFull_q, fifoFull_d;
  logic overrun_q, overrun_d;
  logic [FIFO_ADDR_BITS-1:0] wrPtr_q, wrPtr_d;
  logic [FIFO_ADDR_BITS-1:0] rdPtr_q, rdPtr_d;
  logic [FIFO_ADDR_BITS:0]   count_q, count_d;
  logic [N_BITS_DATA-1:0]    mem_q [DEPTH];
  logic push, pop, doWrite, tmoHit;

`ifdef UART_AUX_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmoCnt_q;
  logic timeout_q;
  logic waitingOperand;

  // The counter only runs while a frame is partially received; any byte restarts it.
  assign waitingOperand = (rxState_q == GET_B) || (rxState_q == GET_OP);
  assign tmoHit = waitingOperand && !rx_done_i && (tmoCnt_q == TMO_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      tmoCnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= tmoHit;
      if (!waitingOperand || rx_done_i || tmoHit) tmoCnt_q <= '0;
      else tmoCnt_q <= tmoCnt_q + TMO_W'(1);
    end
  end

  assign timeout_o = timeout_q;
`else
  assign tmoHit    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    rxState_d = rxState_q;
    aluA_d    = aluA_q;
    aluB_d    = aluB_q;
    aluOp_d   = aluOp_q;
    case (rxState_q)
      GET_A: begin
        if (rx_done_i) begin
          aluA_d    = rx_data_i;
          rxState_d = GET_B;
        end
      end
      GET_B: begin
        if (rx_done_i) begin
          aluB_d    = rx_data_i;
          rxState_d = GET_OP;
        end else if (tmoHit) begin
          rxState_d = GET_A;
        end
      end
      GET_OP: begin
        if (rx_done_i) begin
          aluOp_d   = rx_data_i[N_BITS_OP-1:0];
          rxState_d = EXEC;
        end else if (tmoHit) begin
          rxState_d = GET_A;
        end
      end
      EXEC:    rxState_d = GET_A;
      default: rxState_d = GET_A;
    endcase
  end

  // A write into a full FIFO still lands when the TX side frees a slot in the same cycle.
  assign push    = (rxState_q == EXEC);
  assign pop     = (txState_q == TX_IDLE) && (count_q != '0);
  assign doWrite = push && (!fifoFull_q || pop);

  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    count_d   = count_q;
    overrun_d = overrun_q | (push & fifoFull_q & ~pop);
    if (doWrite) wrPtr_d = wrPtr_q + FIFO_ADDR_BITS'(1);
    if (pop)     rdPtr_d = rdPtr_q + FIFO_ADDR_BITS'(1);
    if (doWrite && !pop)      count_d = count_q + (FIFO_ADDR_BITS+1)'(1);
    else if (!doWrite && pop) count_d = count_q - (FIFO_ADDR_BITS+1)'(1);
    fifoFull_d = (count_d == CNT_FULL);
  end

  always_comb begin
    txState_d = txState_q;
    txData_d  = txData_q;
    txStart_d = 1'b0;
    case (txState_q)
      TX_IDLE: begin
        if (pop) begin
          txData_d  = mem_q[rdPtr_q];
          txStart_d = 1'b1;
          txState_d = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (tx_done_i) txState_d = TX_IDLE;
      end
      default: txState_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rxState_q  <= GET_A;
      txState_q  <= TX_IDLE;
      aluA_q     <= '0;
      aluB_q     <= '0;
      aluOp_q    <= '0;
      txData_q   <= '0;
      txStart_q  <= 1'b0;
      fifoFull_q <= 1'b0;
      overrun_q  <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
    end else begin
      rxState_q  <= rxState_d;
      txState_q  <= txState_d;
      aluA_q     <= aluA_d;
      aluB_q     <= aluB_d;
      aluOp_q    <= aluOp_d;
      txData_q   <= txData_d;
      txStart_q  <= txStart_d;
      fifoFull_q <= fifoFull_d;
      overrun_q  <= overrun_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: only slots covered by the count are ever read.
  always_ff @(posedge clock) begin
    if (doWrite) mem_q[wrPtr_q] <= alu_result_i;
  end

  assign alu_a_o     = aluA_q;
  assign alu_b_o     = aluB_q;
  assign alu_op_o    = aluOp_q;
  assign tx_start_o  = txStart_q;
  assign tx_data_o   = txData_q;
  assign fifo_full_o = fifoFull_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_alu_bridge.sv
// Self-checking bench for uart_alu_bridge: random frames against a queue-based model of
// results and transmitted bytes, with a behavioural ALU closing the loop.

module tb_uart_alu_bridge;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] rx_data_i;
  logic       rx_done_i;
  logic [7:0] alu_a_o, alu_b_o;
  logic [5:0] alu_op_o;
  logic [7:0] alu_result_i;
  logic       tx_start_o;
  logic [7:0] tx_data_o;
  logic       tx_done_i;
  logic       fifo_full_o, overrun_o, timeout_o;

  int vectors = 0;
  int miscompares = 0;
  int cycleCnt = 0;
  int ackCnt = 0;
  logic [7:0] txLog[$];
  int txCyc[$];
  logic [5:0] OPS [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h11};

  uart_alu_bridge #(
    .N_BITS_DATA(8), .N_BITS_OP(6), .FIFO_ADDR_BITS(2), .TIMEOUT_CYCLES(100)
  ) dut (
    .clock(clock), .reset(reset),
    .rx_data_i(rx_data_i), .rx_done_i(rx_done_i),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
    .alu_result_i(alu_result_i),
    .tx_start_o(tx_start_o), .tx_data_o(tx_data_o), .tx_done_i(tx_done_i),
    .fifo_full_o(fifo_full_o), .overrun_o(overrun_o), .timeout_o(timeout_o)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] aluModel(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  assign alu_result_i = aluModel(alu_a_o, alu_b_o, alu_op_o);

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  // Record every transmit start with the byte presented and the cycle it appeared in.
  always @(posedge clock) begin
    #1;
    if (tx_start_o === 1'b1) begin
      txLog.push_back(tx_data_o);
      txCyc.push_back(cycleCnt);
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached (required: bench completes)");
    $fatal(1, "[TB] watchdog");
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b, input logic done);
    rx_data_i = b;
    rx_done_i = 1'b1;
    tx_done_i = done;
    cycle();
    rx_done_i = 1'b0;
    tx_done_i = 1'b0;
    rx_data_i = 8'($urandom);
  endtask

  task automatic sendFrame(output logic [7:0] res);
    logic [7:0] a, b, opByte;
    a = 8'($urandom);
    b = 8'($urandom);
    opByte = {2'($urandom), OPS[$urandom_range(0, 5)]};
    sendByte(a, 1'b0);
    sendByte(b, 1'b0);
    sendByte(opByte, 1'b0);
    cycle();
    res = aluModel(a, b, opByte[5:0]);
  endtask

  task automatic applyReset();
    reset = 1'b1;
    rx_done_i = 1'b0;
    tx_done_i = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    txLog.delete();
    txCyc.delete();
    ackCnt = 0;
  endtask

  // Waits for the next unacknowledged start, then returns tx_done_i for one cycle.
  task automatic drainOne();
    int waitCnt;
    waitCnt = 0;
    while (txLog.size() <= ackCnt && waitCnt < 50) begin
      cycle();
      waitCnt++;
    end
    vectors++;
    if (txLog.size() <= ackCnt) begin
      miscompares++;
      $display("[TB] FAIL drain_wait: starts seen %0d, required more than %0d within 50 cycles", txLog.size(), ackCnt);
    end else begin
      tx_done_i = 1'b1;
      cycle();
      tx_done_i = 1'b0;
      ackCnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_done_i = 1'b0;
    tx_done_i = 1'b0;
    rx_data_i = 8'h00;
    cycle();
    cycle();
    vectors += 8;
    if (alu_a_o !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_alu_a: got %h want 00", alu_a_o); end
    if (alu_b_o !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_alu_b: got %h want 00", alu_b_o); end
    if (alu_op_o !== 6'h00) begin miscompares++; $display("[TB] FAIL reset_alu_op: got %h want 00", alu_op_o); end
    if (tx_start_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tx_start: got %b want 0", tx_start_o); end
    if (tx_data_o !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_tx_data: got %h want 00", tx_data_o); end
    if (fifo_full_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_fifo_full: got %b want 0", fifo_full_o); end
    if (overrun_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overrun: got %b want 0", overrun_o); end
    if (timeout_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_timeout: got %b want 0", timeout_o); end
    reset = 1'b0;
    txLog.delete();
    txCyc.delete();
    ackCnt = 0;
  endtask

  task automatic test_basic_frame();
    int kOp;
    logic [7:0] a1, b1, a2, b2, op1, op2, junk, r1, r2;
    applyReset();
    sendByte(8'h05, 1'b0);
    vectors += 2;
    if (alu_a_o !== 8'h05) begin miscompares++; $display("[TB] FAIL basic_a: got %h want 05", alu_a_o); end
    if (alu_b_o !== 8'h00) begin miscompares++; $display("[TB] FAIL basic_b_before: got %h want 00", alu_b_o); end
    sendByte(8'h03, 1'b0);
    vectors += 2;
    if (alu_b_o !== 8'h03) begin miscompares++; $display("[TB] FAIL basic_b: got %h want 03", alu_b_o); end
    if (alu_a_o !== 8'h05) begin miscompares++; $display("[TB] FAIL basic_a_hold: got %h want 05", alu_a_o); end
    kOp = cycleCnt;
    sendByte(8'h20, 1'b0);
    vectors++;
    if (alu_op_o !== 6'h20) begin miscompares++; $display("[TB] FAIL basic_op: got %h want 20", alu_op_o); end
    repeat (5) cycle();
    vectors++;
    if (txLog.size() !== 1) begin
      miscompares++;
      $display("[TB] FAIL basic_start_count: got %0d want 1", txLog.size());
    end else begin
      vectors += 3;
      if (txLog[0] !== 8'h08) begin miscompares++; $display("[TB] FAIL basic_tx_data: got %h want 08", txLog[0]); end
      if (txCyc[0] !== kOp + 3) begin miscompares++; $display("[TB] FAIL basic_latency: start at %0d want %0d", txCyc[0], kOp + 3); end
      if (tx_data_o !== 8'h08) begin miscompares++; $display("[TB] FAIL basic_tx_hold: got %h want 08", tx_data_o); end
    end
    drainOne();

    // A byte arriving during EXEC must be lost, so the following byte is operand A.
    a1 = 8'($urandom); b1 = 8'($urandom); op1 = {2'b00, OPS[$urandom_range(0, 5)]};
    a2 = 8'($urandom); b2 = 8'($urandom); op2 = {2'b11, OPS[$urandom_range(0, 5)]};
    junk = a2 ^ 8'h5A;
    r1 = aluModel(a1, b1, op1[5:0]);
    r2 = aluModel(a2, b2, op2[5:0]);
    sendByte(a1, 1'b0);
    sendByte(b1, 1'b0);
    sendByte(op1, 1'b0);
    sendByte(junk, 1'b0);
    sendByte(a2, 1'b0);
    vectors++;
    if (alu_a_o !== a2) begin miscompares++; $display("[TB] FAIL exec_byte_lost: alu_a got %h want %h", alu_a_o, a2); end
    sendByte(b2, 1'b0);
    sendByte(op2, 1'b0);
    vectors++;
    if (alu_op_o !== op2[5:0]) begin miscompares++; $display("[TB] FAIL op_slice: got %h want %h", alu_op_o, op2[5:0]); end
    cycle();
    drainOne();
    drainOne();
    vectors++;
    if (txLog.size() !== 3) begin
      miscompares++;
      $display("[TB] FAIL exec_start_count: got %0d want 3", txLog.size());
    end else begin
      vectors += 2;
      if (txLog[1] !== r1) begin miscompares++; $display("[TB] FAIL exec_result1: got %h want %h", txLog[1], r1); end
      if (txLog[2] !== r2) begin miscompares++; $display("[TB] FAIL exec_result2: got %h want %h", txLog[2], r2); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] res [6];
    applyReset();
    for (int i = 0; i < 6; i++) begin
      sendFrame(res[i]);
      if (i == 3) begin
        vectors++;
        if (fifo_full_o !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_full_early: got %b want 0", fifo_full_o); end
      end
      if (i == 4) begin
        vectors += 2;
        if (fifo_full_o !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_full: got %b want 1", fifo_full_o); end
        if (overrun_o !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_overrun_early: got %b want 0", overrun_o); end
      end
      if (i == 5) begin
        vectors += 2;
        if (overrun_o !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_overrun: got %b want 1", overrun_o); end
        if (fifo_full_o !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_full_after_drop: got %b want 1", fifo_full_o); end
      end
    end
    for (int i = 0; i < 5; i++) drainOne();
    repeat (6) cycle();
    vectors += 3;
    if (overrun_o !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_overrun_sticky: got %b want 1", overrun_o); end
    if (fifo_full_o !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_full_after_drain: got %b want 0", fifo_full_o); end
    if (txLog.size() !== 5) begin
      miscompares++;
      $display("[TB] FAIL b2b_start_count: got %0d want 5", txLog.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (txLog[i] !== res[i]) begin miscompares++; $display("[TB] FAIL b2b_order[%0d]: got %h want %h", i, txLog[i], res[i]); end
      end
    end
  endtask

  task automatic test_full_pop_same_cycle();
    logic [7:0] res [6];
    logic [7:0] a, b, opByte;
    applyReset();
    for (int i = 0; i < 5; i++) sendFrame(res[i]);
    vectors++;
    if (fifo_full_o !== 1'b1) begin miscompares++; $display("[TB] FAIL same_full_setup: got %b want 1", fifo_full_o); end
    a = 8'($urandom); b = 8'($urandom); opByte = {2'($urandom), OPS[$urandom_range(0, 5)]};
    res[5] = aluModel(a, b, opByte[5:0]);
    sendByte(a, 1'b0);
    sendByte(b, 1'b0);
    sendByte(opByte, 1'b1);
    ackCnt++;
    cycle();
    vectors += 2;
    if (overrun_o !== 1'b0) begin miscompares++; $display("[TB] FAIL same_overrun: got %b want 0", overrun_o); end
    if (fifo_full_o !== 1'b1) begin miscompares++; $display("[TB] FAIL same_full: got %b want 1", fifo_full_o); end
    for (int i = 0; i < 5; i++) drainOne();
    repeat (6) cycle();
    vectors++;
    if (txLog.size() !== 6) begin
      miscompares++;
      $display("[TB] FAIL same_start_count: got %0d want 6", txLog.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (txLog[i] !== res[i]) begin miscompares++; $display("[TB] FAIL same_order[%0d]: got %h want %h", i, txLog[i], res[i]); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] expQ[$];
    logic [7:0] r;
    int sent, burst;
    applyReset();
    sent = 0;
    while (sent < 10) begin
      burst = $urandom_range(1, 3);
      if (burst > 10 - sent) burst = 10 - sent;
      for (int j = 0; j < burst; j++) begin
        sendFrame(r);
        expQ.push_back(r);
        sent++;
      end
      vectors += 2;
      if (fifo_full_o !== 1'b0) begin miscompares++; $display("[TB] FAIL wrap_spurious_full: got %b want 0", fifo_full_o); end
      if (overrun_o !== 1'b0) begin miscompares++; $display("[TB] FAIL wrap_overrun: got %b want 0", overrun_o); end
      for (int j = 0; j < burst; j++) drainOne();
    end
    repeat (4) cycle();
    vectors++;
    if (txLog.size() !== 10) begin
      miscompares++;
      $display("[TB] FAIL wrap_start_count: got %0d want 10", txLog.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        vectors++;
        if (txLog[i] !== expQ[i]) begin miscompares++; $display("[TB] FAIL wrap_seq[%0d]: got %h want %h", i, txLog[i], expQ[i]); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] r, a, b, opByte;
    applyReset();
    sendFrame(r);
    sendFrame(r);
    sendByte(8'($urandom), 1'b0);
    sendByte(8'($urandom), 1'b0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    txLog.delete();
    txCyc.delete();
    ackCnt = 0;
    vectors += 4;
    if (alu_a_o !== 8'h00) begin miscompares++; $display("[TB] FAIL midrst_alu_a: got %h want 00", alu_a_o); end
    if (alu_b_o !== 8'h00) begin miscompares++; $display("[TB] FAIL midrst_alu_b: got %h want 00", alu_b_o); end
    if (alu_op_o !== 6'h00) begin miscompares++; $display("[TB] FAIL midrst_alu_op: got %h want 00", alu_op_o); end
    if (fifo_full_o !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_full: got %b want 0", fifo_full_o); end
    repeat (5) cycle();
    tx_done_i = 1'b1;
    cycle();
    tx_done_i = 1'b0;
    repeat (4) cycle();
    vectors++;
    if (txLog.size() !== 0) begin miscompares++; $display("[TB] FAIL midrst_no_start: got %0d starts want 0", txLog.size()); end
    a = 8'($urandom); b = 8'($urandom); opByte = {2'($urandom), OPS[$urandom_range(0, 5)]};
    sendByte(a, 1'b0);
    vectors += 2;
    if (alu_a_o !== a) begin miscompares++; $display("[TB] FAIL midrst_fresh_a: got %h want %h", alu_a_o, a); end
    if (alu_b_o !== 8'h00) begin miscompares++; $display("[TB] FAIL midrst_b_unlatched: got %h want 00", alu_b_o); end
    sendByte(b, 1'b0);
    sendByte(opByte, 1'b0);
    repeat (5) cycle();
    vectors++;
    if (txLog.size() !== 1) begin
      miscompares++;
      $display("[TB] FAIL midrst_start_count: got %0d want 1", txLog.size());
    end else begin
      vectors++;
      if (txLog[0] !== aluModel(a, b, opByte[5:0])) begin
        miscompares++;
        $display("[TB] FAIL midrst_result: got %h want %h", txLog[0], aluModel(a, b, opByte[5:0]));
      end
    end
    drainOne();
  endtask

  task automatic test_timeout();
    int pulses, expPulses;
    logic [7:0] a, x;
`ifdef UART_AUX_TIMEOUT_EN
    expPulses = 1;
`else
    expPulses = 0;
`endif
    applyReset();
    a = 8'($urandom);
    x = 8'($urandom);
    sendByte(a, 1'b0);
    pulses = 0;
    for (int i = 0; i < 150; i++) begin
      if (timeout_o === 1'b1) pulses++;
      cycle();
    end
    vectors++;
    if (pulses !== expPulses) begin miscompares++; $display("[TB] FAIL timeout_pulses: got %0d want %0d", pulses, expPulses); end
    sendByte(x, 1'b0);
    vectors += 2;
    if (expPulses == 1) begin
      if (alu_a_o !== x) begin miscompares++; $display("[TB] FAIL timeout_relatch_a: got %h want %h", alu_a_o, x); end
      if (alu_b_o !== 8'h00) begin miscompares++; $display("[TB] FAIL timeout_b_kept: got %h want 00", alu_b_o); end
    end else begin
      if (alu_b_o !== x) begin miscompares++; $display("[TB] FAIL wait_forever_b: got %h want %h", alu_b_o, x); end
      if (alu_a_o !== a) begin miscompares++; $display("[TB] FAIL wait_forever_a: got %h want %h", alu_a_o, a); end
    end
  endtask

  initial begin
    reset = 1'b1;
    rx_data_i = 8'h00;
    rx_done_i = 1'b0;
    tx_done_i = 1'b0;
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_full_pop_same_cycle();
    test_wrap();
    test_reset_midframe();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
